iter_cmp_unit: RTL and testbench

- Multi-cycle, parametrised compare unit for the RISC-V core.
- Generalises the single-cycle sltu/slt path to a configurable operand width.
- Compares MSB-first, DIGIT bits per cycle, and terminates early on the first differing digit.
- Covers slt/sltu and all branch conditions (eq/ne/lt/ge/ltu/geu) behind a start/valid handshake. Sits beside the ALU; the control FSM stalls on busy.

---
 rtl/iter_cmp_unit.sv | 125 ++++++++++++
 tb/tb_iter_cmp_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_cmp_unit.sv
// Multi-cycle MSB-first compare unit: DIGIT bits per cycle, early exit on the
// first differing digit. Covers eq/ne/lt/ge/ltu/geu behind start/valid.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | comparing one digit per cycle, busy high
// S_DONE | one-cycle valid pulse, result presented; may accept again
module iter_cmp_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] res,
  output logic             ill_op
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("iter_cmp_unit: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [KW-1:0]    k_q, k_d;
  logic             res_q, res_d;
  logic             ill_q, ill_d;

  // Operands are shifted left each step, so the digit under test is always on top.
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_eq, dig_lt, is_signed;

  assign dig_a     = a_q[WIDTH-1 -: DIGIT];
  assign dig_b     = b_q[WIDTH-1 -: DIGIT];
  assign dig_eq    = (dig_a == dig_b);
  assign dig_lt    = (dig_a < dig_b);
  // Flipping the sign bit turns a signed compare into an unsigned one.
  assign is_signed = op[2] & ~op[1];

  // Next-state, operand stepping and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    k_d     = k_q;
    res_d   = res_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = KW'(NDIG - 1);
          op_d    = op;
          a_d     = is_signed ? (a ^ MSB_MASK) : a;
          b_d     = is_signed ? (b ^ MSB_MASK) : b;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!dig_eq || (k_q == '0)) begin
          state_d = S_DONE;
          ill_d   = 1'b0;
          case (op_q)
            3'b000:         res_d = dig_eq;
            3'b001:         res_d = ~dig_eq;
            3'b100, 3'b110: res_d = dig_lt;
            3'b101, 3'b111: res_d = ~dig_lt;
            default: begin
              res_d = 1'b0;
              ill_d = 1'b1;
            end
          endcase
        end else begin
          k_d = k_q - KW'(1);
          a_d = a_q << DIGIT;
          b_d = b_q << DIGIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      k_q     <= '0;
      res_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      k_q     <= k_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign valid  = (state_q == S_DONE);
  assign res    = WIDTH'(res_q);
  assign ill_op = ill_q;

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Bench for iter_cmp_unit: directed cases plus random ops against a
// reference model built from signed/unsigned arithmetic.
module tb_iter_cmp_unit;

  logic        clk, rst;
  logic        start, busy, valid, ill_op;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, res;
  logic        start8, busy8, valid8, ill8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;

  int tests_run = 0;
  int tests_failed = 0;

  iter_cmp_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .valid(valid), .res(res), .ill_op(ill_op)
  );

  iter_cmp_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .valid(valid8), .res(res8), .ill_op(ill8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    longint r;
    r = longint'(v);
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int w, input int d);
    longint m;
    m = (longint'(1) << d) - 1;
    for (int j = 1; j <= w / d; j++) begin
      int sh;
      sh = w - j * d;
      if (((longint'(a) >> sh) & m) != ((longint'(b) >> sh) & m)) return j;
    end
    return w / d;
  endfunction

  // returns {ill, res}
  function automatic logic [1:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'b000:  return {1'b0, ua == ub};
      3'b001:  return {1'b0, ua != ub};
      3'b100:  return {1'b0, sx(a, w) < sx(b, w)};
      3'b101:  return {1'b0, sx(a, w) >= sx(b, w)};
      3'b110:  return {1'b0, ua < ub};
      3'b111:  return {1'b0, ua >= ub};
      default: return 2'b10;
    endcase
  endfunction

  // One request on the 32-bit unit; poke >= 0 drives a stray start in that RUN cycle.
  task automatic do32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int idle, input int poke);
    int cyc, busy_cnt, lat;
    logic [1:0] exp;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0;
    exp = ref_res(op, a, b, 32);
    lat = ref_lat(a, b, 32, 8);
    cyc = 0; busy_cnt = 0;
    while (!valid && cyc < 8) begin
      if (busy) busy_cnt++;
      if (cyc == poke) begin
        @(negedge clk);
        start = 1'b1; a_i = 32'd0; b_i = 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("valid32", 32'(valid), 32'd1);
    check("lat32", 32'(cyc), 32'(lat));
    check("busy32", 32'(busy_cnt), 32'(lat));
    check("res32", res, {31'd0, exp[0]});
    check("ill32", 32'(ill_op), 32'(exp[1]));
  endtask

  task automatic do8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int cyc, lat;
    logic [1:0] exp;
    @(negedge clk);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    exp = ref_res(op, {24'd0, a}, {24'd0, b}, 8);
    lat = ref_lat({24'd0, a}, {24'd0, b}, 8, 1);
    cyc = 0;
    while (!valid8 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("valid8", 32'(valid8), 32'd1);
    check("lat8", 32'(cyc), 32'(lat));
    check("res8", {24'd0, res8}, {31'd0, exp[0]});
    check("ill8", 32'(ill8), 32'(exp[1]));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int saw_valid;
    rst = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_ill", 32'(ill_op), 32'd0);
    check("rst_valid8", 32'(valid8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do32(3'b110, 32'h8, 32'd2, 1, -1);
    do32(3'b110, 32'hfffffff8, 32'd2, 0, -1);
    do32(3'b100, 32'hfffffff8, 32'd2, 0, -1);
    do32(3'b111, 32'hfffffff8, 32'd2, 0, -1);
    do32(3'b101, 32'hfffffff8, 32'd2, 0, -1);
    do32(3'b110, 32'd2, 32'd4, 1, -1);
    // back-to-back: each of these starts during the previous DONE
    do32(3'b000, 32'h12345678, 32'h12345678, 0, -1);
    do32(3'b001, 32'h12345678, 32'h12345678, 0, -1);
    do32(3'b001, 32'h12345678, 32'h12345679, 0, -1);
    do32(3'b010, 32'd1, 32'd2, 0, -1);
    do32(3'b011, 32'd5, 32'd5, 0, -1);
    do32(3'b110, 32'd1, 32'd2, 0, -1);

    // result holds after the valid pulse
    @(posedge clk); #1;
    check("hold_valid", 32'(valid), 32'd0);
    check("hold_res", res, 32'd1);
    @(posedge clk); #1;
    check("hold_res2", res, 32'd1);

    // stray start during RUN is ignored
    do32(3'b110, 32'd2, 32'd4, 1, 1);

    // reset mid-RUN aborts the operation
    @(negedge clk);
    start = 1'b1; op_i = 3'b110; a_i = 32'd2; b_i = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_res", res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (valid) saw_valid++;
    end
    check("abort_novalid", 32'(saw_valid), 32'd0);
    do32(3'b110, 32'd2, 32'd4, 0, -1);

    // single-bit digits on the 8-bit instance
    do8(3'b100, 8'h80, 8'h7f);
    do8(3'b100, 8'h01, 8'h00);
    do8(3'b110, 8'h80, 8'h7f);
    do8(3'b000, 8'h5a, 8'h5a);
    for (int i = 0; i < 20; i++)
      do8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ ((32'($urandom_range(1, 255))) << (8 * $urandom_range(0, 3)));
        default: rb = $urandom;
      endcase
      do32(rop, ra, rb, $urandom_range(0, 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
